image_pipe_frame_arb: RTL and testbench
=======================================

# image_pipe_frame_arb

Frame-granular round-robin arbiter that shares one image_pipe datapath between two image sources. It grants the downstream stream to one source for a whole frame, from the first word to the word flagged end. It forwards words through a 2-entry output buffer under the valid/busy handshake, and keeps per-source completed-frame counters. It sits directly in front of the image_pipe input port.

## Interface
Parameters:
- DW, 32, data width of every stream port
- CNT_W, 16, width of each frame counter

Ports:
- clk  in  1  single clock, all logic on posedge
- s_rst  in  1  synchronous reset, active-high
- s0_data_in  in  DW  source 0 word
- s0_valid_in  in  1  source 0 word valid
- s0_end_in  in  1  marks source 0's last word of frame (qualified by valid)
- s0_busy_out  out  1  source 0 must hold its word
- s1_data_in / s1_valid_in / s1_end_in / s1_busy_out  same as source 0, for source 1
- m_data_out  out  DW  word to image_pipe
- m_valid_out  out  1  word valid
- m_end_out  out  1  last word of frame
- m_busy_in  in  1  downstream holding
- src_en  in  2  per-source enable; bit i=0 stops new grants to source i
- grant  out  2  one-hot current owner, 00 when idle
- frame_cnt0, frame_cnt1  out  CNT_W  frames completed per source

## Operation
- Handshake on every port: a word transfers in a cycle where valid=1 and busy=0. Sources hold data, valid and end while busy=1.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Candidate i means sI_valid_in=1 and src_en[i]=1.
  - With one candidate, grant it. With two, grant the source not served last (last_owner register, reset value 1, so source 0 wins first).
  - Transition to OWN0 or OWN1 on the next edge. No word is accepted in IDLE.
- OWNi:
  - sI_busy_out = (fifo_cnt==2). The non-owner's busy_out=1.
  - An accepted word is pushed into the FIFO with its end bit.
  - An accepted word with end=1 returns the FSM to IDLE, sets last_owner=i, and increments frame_cntI.
- src_en deassert mid-frame does not abort; the frame completes.
- In IDLE, both busy_out=1.
- Output FIFO, 2 entries of {data, end}:
  - Head drives m_data_out and m_end_out; m_valid_out = (fifo_cnt!=0).
  - Pop when m_valid_out=1 and m_busy_in=0. Push and pop in the same cycle leave the count unchanged.
  - Push is never attempted when full.
- Counters wrap from 2^CNT_W-1 to 0.
- Words are passed unmodified. m_end_out is only meaningful with m_valid_out=1.

## Timing
- Reset values:
  - grant=00, state IDLE, fifo_cnt=0.
  - m_valid_out=0, m_end_out=0, m_data_out=0.
  - frame_cnt0=frame_cnt1=0.
  - s0_busy_out=s1_busy_out=1, last_owner=1.
- Arbitration latency: a candidate seen in IDLE at edge N gets grant at N+1. Its first word can be accepted in cycle N+1.
- Data latency: a word accepted in cycle N is on m_*_out in cycle N+1 if the FIFO was empty.
- Throughput is 1 word/cycle within a frame. There is 1 idle cycle between frames (the IDLE visit).
- busy_out is combinational from state and fifo_cnt only. It never depends on m_busy_in in the same cycle, so there is no in→out comb path.
- Frame counters and last_owner update on the edge that accepts the end word.
- s_rst=1 at any time, including mid-frame, returns everything to the reset values on that edge. Buffered words are dropped and a partial frame is not counted.

## Test plan
- Single source:
  - Stimulus: src_en=11; s0 sends a 4-word frame (0x10..0x13, end on 0x13); m_busy_in=0.
  - Required: grant=01 one cycle after s0_valid; m_valid_out asserted for 4 consecutive cycles starting one cycle after the first accepted word; m_end_out with 0x13; frame_cnt0=1; grant returns to 00.
- Contention round-robin:
  - Stimulus: both sources continuously offer 2-word frames from reset.
  - Required: owner order is s0, s1, s0, s1; after 4 frames, frame_cnt0=2 and frame_cnt1=2; one idle cycle between frames.
- Backpressure:
  - Stimulus: s1 owns; m_busy_in=1 for 5 cycles mid-frame.
  - Required: FIFO fills to 2; s1_busy_out=1; m_data_out holds; no loss or duplication; word order intact after release.
- Enable masking:
  - Stimulus: src_en=10 with both valid; then clear src_en[1] after s1's first word.
  - Required: only s1 granted; its frame completes; afterwards no grant while src_en=00.
- Counter wrap:
  - Stimulus: CNT_W=2; s0 sends 5 frames.
  - Required: frame_cnt0 reads 1.
- Reset mid-frame:
  - Stimulus: assert s_rst during word 2 of a 4-word frame.
  - Required: next cycle grant=00, m_valid_out=0, frame_cnt0 unchanged from 0, both busy_out=1.

Source files
------------

// File: rtl/image_pipe_frame_arb.sv
// Frame-granular round-robin arbiter: one source owns the output for a whole
// frame; accepted words pass through a 2-entry {data,end} buffer to image_pipe.
module image_pipe_frame_arb #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic [DW-1:0]    s0_data_in,
  input  logic             s0_valid_in,
  input  logic             s0_end_in,
  output logic             s0_busy_out,
  input  logic [DW-1:0]    s1_data_in,
  input  logic             s1_valid_in,
  input  logic             s1_end_in,
  output logic             s1_busy_out,
  output logic [DW-1:0]    m_data_out,
  output logic             m_valid_out,
  output logic             m_end_out,
  input  logic             m_busy_in,
  input  logic [1:0]       src_en,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] frame_cnt0,
  output logic [CNT_W-1:0] frame_cnt1
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state;
  logic              last_owner;
  logic [1:0]        fifo_cnt;
  logic [DW-1:0]     fifo_data [2];
  logic              fifo_end  [2];
  logic              rd_ptr;
  logic              wr_ptr;

  logic              full;
  logic              cand0;
  logic              cand1;
  logic              acc0;
  logic              acc1;
  logic              push;
  logic              pop;
  logic [DW-1:0]     push_data;
  logic              push_end;

  // Frame counters wrap naturally at 2^CNT_W.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return v + one;
  endfunction

  // Source-side handshake: busy depends only on state and fill level.
  always_comb begin
    full        = (fifo_cnt == 2'd2);
    cand0       = s0_valid_in && src_en[0];
    cand1       = s1_valid_in && src_en[1];
    s0_busy_out = (state != OWN0) || full;
    s1_busy_out = (state != OWN1) || full;
    acc0        = (state == OWN0) && s0_valid_in && !full;
    acc1        = (state == OWN1) && s1_valid_in && !full;
    push        = acc0 || acc1;
    push_data   = acc1 ? s1_data_in : s0_data_in;
    push_end    = acc1 ? s1_end_in  : s0_end_in;
  end

  // Downstream side: head of the buffer drives the output port.
  always_comb begin
    m_valid_out = (fifo_cnt != 2'd0);
    m_data_out  = fifo_data[rd_ptr];
    m_end_out   = fifo_end[rd_ptr];
    pop         = m_valid_out && !m_busy_in;
  end

  // Ownership FSM; grant and counters are registered with the state.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cand0 && (!cand1 || last_owner)) begin
            state <= OWN0;
            grant <= 2'b01;
          end else if (cand1) begin
            state <= OWN1;
            grant <= 2'b10;
          end
        end
        OWN0: begin
          if (acc0 && s0_end_in) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b0;
            frame_cnt0 <= cnt_inc(frame_cnt0);
          end
        end
        OWN1: begin
          if (acc1 && s1_end_in) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b1;
            frame_cnt1 <= cnt_inc(frame_cnt1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Output buffer; storage is cleared on reset so the idle head reads zero.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      fifo_cnt     <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_end[0]  <= 1'b0;
      fifo_end[1]  <= 1'b0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_end[wr_ptr]  <= push_end;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_image_pipe_frame_arb.sv
// Directed bench for image_pipe_frame_arb: grant timing, round-robin order,
// backpressure, enable masking, counter wrap and mid-frame reset.
module tb_image_pipe_frame_arb;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          s_rst;
  logic [DW-1:0] s0_data_in, s1_data_in;
  logic          s0_valid_in, s0_end_in, s1_valid_in, s1_end_in;
  logic          s0_busy_out, s1_busy_out;
  logic [DW-1:0] m_data_out;
  logic          m_valid_out, m_end_out, m_busy_in;
  logic [1:0]    src_en, grant;
  logic [15:0]   frame_cnt0, frame_cnt1;

  logic          w_s0_busy, w_s1_busy, w_m_valid, w_m_end;
  logic [DW-1:0] w_m_data;
  logic [1:0]    w_grant;
  logic [1:0]    w_frame_cnt0, w_frame_cnt1;

  int total = 0;
  int bad   = 0;
  logic [DW:0] s0_q[$], s1_q[$], exp_q[$];
  logic [1:0]  rr_exp [12] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                               2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};

  always #5 clk = ~clk;

  image_pipe_frame_arb #(.DW(DW), .CNT_W(16)) dut (
    .clk(clk), .s_rst(s_rst),
    .s0_data_in(s0_data_in), .s0_valid_in(s0_valid_in), .s0_end_in(s0_end_in), .s0_busy_out(s0_busy_out),
    .s1_data_in(s1_data_in), .s1_valid_in(s1_valid_in), .s1_end_in(s1_end_in), .s1_busy_out(s1_busy_out),
    .m_data_out(m_data_out), .m_valid_out(m_valid_out), .m_end_out(m_end_out), .m_busy_in(m_busy_in),
    .src_en(src_en), .grant(grant), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1)
  );

  image_pipe_frame_arb #(.DW(DW), .CNT_W(2)) dut_w (
    .clk(clk), .s_rst(s_rst),
    .s0_data_in(s0_data_in), .s0_valid_in(s0_valid_in), .s0_end_in(s0_end_in), .s0_busy_out(w_s0_busy),
    .s1_data_in(s1_data_in), .s1_valid_in(s1_valid_in), .s1_end_in(s1_end_in), .s1_busy_out(w_s1_busy),
    .m_data_out(w_m_data), .m_valid_out(w_m_valid), .m_end_out(w_m_end), .m_busy_in(m_busy_in),
    .src_en(src_en), .grant(w_grant), .frame_cnt0(w_frame_cnt0), .frame_cnt1(w_frame_cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive queue heads, score accepted/emitted words, advance.
  task automatic cyc();
    logic a0, a1, o;
    s0_valid_in = (s0_q.size() != 0);
    {s0_end_in, s0_data_in} = s0_valid_in ? s0_q[0] : '0;
    s1_valid_in = (s1_q.size() != 0);
    {s1_end_in, s1_data_in} = s1_valid_in ? s1_q[0] : '0;
    a0 = s0_valid_in && !s0_busy_out;
    a1 = s1_valid_in && !s1_busy_out;
    o  = m_valid_out && !m_busy_in;
    if (o) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL out_extra observed=0x%0h expected=none", {m_end_out, m_data_out});
      end
      if (exp_q.size() != 0)
        chk("out_word", {m_end_out, m_data_out}, exp_q.pop_front());
    end
    if (a0) exp_q.push_back(s0_q.pop_front());
    if (a1) exp_q.push_back(s1_q.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    s0_q.delete(); s1_q.delete(); exp_q.delete();
    s0_valid_in = 1'b0; s1_valid_in = 1'b0;
    s0_end_in = 1'b0; s1_end_in = 1'b0;
    s0_data_in = '0; s1_data_in = '0;
    m_busy_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (s0_q.size() == 0 && s1_q.size() == 0 && exp_q.size() == 0 && !m_valid_out) begin
        done = 1'b1;
        break;
      end
      cyc();
    end
    total++;
    assert (done) else begin
      bad++;
      $error("FAIL drain_timeout observed=%0d pending expected=0", exp_q.size());
    end
  endtask

  initial begin
    src_en = 2'b00;
    do_reset();
    chk("rst_grant", grant, 2'b00);
    chk("rst_m_valid", m_valid_out, 1'b0);
    chk("rst_m_end", m_end_out, 1'b0);
    chk("rst_m_data", m_data_out, 32'h0);
    chk("rst_cnt0", frame_cnt0, 16'd0);
    chk("rst_cnt1", frame_cnt1, 16'd0);
    chk("rst_busy0", s0_busy_out, 1'b1);
    chk("rst_busy1", s1_busy_out, 1'b1);
    chk("rst_w_data", {w_m_end, w_m_data}, 33'h0);
    chk("rst_w_ctl", {w_grant, w_m_valid, w_s0_busy, w_s1_busy, w_frame_cnt1}, 7'b00_0_1_1_00);

    // Single source, 4-word frame
    src_en = 2'b11;
    for (int i = 0; i < 4; i++) s0_q.push_back({(i == 3), 32'h10 + i});
    cyc();
    chk("single_grant", grant, 2'b01);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("single_m_valid", m_valid_out, 1'b1);
      chk("single_m_data", m_data_out, 32'h10 + i);
      chk("single_m_end", m_end_out, (i == 3));
      if (i == 3) begin
        chk("single_grant_idle", grant, 2'b00);
        chk("single_cnt0", frame_cnt0, 16'd1);
      end
      cyc();
    end
    chk("single_m_valid_off", m_valid_out, 1'b0);

    // Contention: both sources always offering 2-word frames
    do_reset();
    src_en = 2'b11;
    for (int f = 0; f < 3; f++) begin
      s0_q.push_back({1'b0, 32'hA00 + 16 * f}); s0_q.push_back({1'b1, 32'hA01 + 16 * f});
      s1_q.push_back({1'b0, 32'hB00 + 16 * f}); s1_q.push_back({1'b1, 32'hB01 + 16 * f});
    end
    for (int c = 0; c < 12; c++) begin
      cyc();
      chk($sformatf("rr_grant_c%0d", c + 1), grant, rr_exp[c]);
    end
    chk("rr_cnt0", frame_cnt0, 16'd2);
    chk("rr_cnt1", frame_cnt1, 16'd2);

    // Backpressure while s1 owns
    do_reset();
    src_en = 2'b11;
    for (int i = 0; i < 6; i++) s1_q.push_back({(i == 5), 32'h30 + i});
    cyc();
    cyc();
    m_busy_in = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("bp_busy1", s1_busy_out, 1'b1);
      chk("bp_m_valid", m_valid_out, 1'b1);
      chk("bp_m_hold", m_data_out, 32'h30);
      cyc();
    end
    m_busy_in = 1'b0;
    drain(50);
    chk("bp_cnt1", frame_cnt1, 16'd1);
    chk("bp_grant_idle", grant, 2'b00);

    // Enable masking
    do_reset();
    src_en = 2'b10;
    s0_q.push_back({1'b0, 32'h40}); s0_q.push_back({1'b1, 32'h41});
    s1_q.push_back({1'b0, 32'h50}); s1_q.push_back({1'b1, 32'h51});
    cyc();
    chk("en_grant_s1", grant, 2'b10);
    cyc();
    src_en = 2'b00;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("en_no_grant", grant, 2'b00);
      cyc();
    end
    chk("en_cnt1", frame_cnt1, 16'd1);
    chk("en_cnt0", frame_cnt0, 16'd0);
    chk("en_s0_untouched", s0_q.size(), 2);
    chk("en_out_done", exp_q.size(), 0);

    // Counter wrap on the CNT_W=2 instance
    do_reset();
    src_en = 2'b01;
    for (int i = 0; i < 5; i++) s0_q.push_back({1'b1, 32'h60 + i});
    drain(100);
    chk("wrap_cnt0_wide", frame_cnt0, 16'd5);
    chk("wrap_cnt0_narrow", w_frame_cnt0, 2'd1);

    // Reset during word 2 of a 4-word frame
    do_reset();
    src_en = 2'b11;
    for (int i = 0; i < 4; i++) s0_q.push_back({(i == 3), 32'h70 + i});
    cyc();
    cyc();
    s_rst = 1'b1;
    cyc();
    s_rst = 1'b0;
    s0_q.delete(); exp_q.delete();
    s0_valid_in = 1'b0;
    chk("mrst_grant", grant, 2'b00);
    chk("mrst_m_valid", m_valid_out, 1'b0);
    chk("mrst_cnt0", frame_cnt0, 16'd0);
    chk("mrst_busy0", s0_busy_out, 1'b1);
    chk("mrst_busy1", s1_busy_out, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
